ram_responder: RTL and testbench

Byte-wide memory responder on the target side of the memory controller's `addr`/`wdata`/`rdata`/`mem_ctrl_wr` bus. It serves a synchronous RAM with one-cycle registered read latency and decodes a small MMIO window. The window holds a console output FIFO, a FIFO status byte and a halt register. It sits between the memory controller and the simulation top or board wrapper, which drains the console FIFO through a valid/ready port.

---
 rtl/ram_responder_pkg.sv | 36 +++
 rtl/ram_responder_io.sv | 50 +++++
 rtl/ram_responder.sv | 120 ++++++++++++
 tb/tb_ram_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared MMIO constants, status byte layout and address decode for ram_responder.
// The MMIO window is enabled by defining RAM_RESPONDER_MMIO_EN.
package ram_responder_pkg;

   localparam int unsigned DATA_W            = 8;
   localparam logic [31:0] IO_CONSOLE_OFFSET = 32'd0;
   localparam logic [31:0] IO_HALT_OFFSET    = 32'd4;
   localparam int unsigned IO_STAT_FULL      = 0;
   localparam int unsigned IO_STAT_EMPTY     = 1;
   localparam int unsigned IO_STAT_OVF       = 2;
   localparam int unsigned IO_STAT_COUNT_LSB = 4;

   // Console status byte as seen on a CONSOLE read.
   typedef struct packed {
      logic [3:0] count;
      logic       rsvd;
      logic       overflow;
      logic       empty;
      logic       full;
   } io_status_t;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_CONSOLE,
      REG_HALT,
      REG_UNMAPPED
   } region_e;

   function automatic region_e decode(input logic [31:0] addr, input logic [31:0] io_base);
      if (addr < io_base) return REG_RAM;
      if (addr == io_base + IO_CONSOLE_OFFSET) return REG_CONSOLE;
      if (addr == io_base + IO_HALT_OFFSET) return REG_HALT;
      return REG_UNMAPPED;
   endfunction

endpackage

// File: rtl/ram_responder_io.sv
// io_fifo: circular console FIFO; a push while full succeeds only when a pop
// happens on the same edge.
module io_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] buf_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
      end else begin
         if (do_push) begin
            buf_q[wr_ptr] <= push_data;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   assign head  = buf_q[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ram_responder.sv
// Byte-wide RAM responder with optional MMIO window (console FIFO, status, halt).
// Define RAM_RESPONDER_MMIO_EN to enable the MMIO window; otherwise all addresses hit RAM.
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ctrl_wr,
   input  logic [31:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        halt
);

   logic [7:0]            mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we;
   logic [7:0]            rd_byte;

   assign ram_addr = addr[ADDR_WIDTH-1:0];

`ifdef RAM_RESPONDER_MMIO_EN
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   region_e          region;
   logic             prev_wr;
   logic [31:0]      prev_addr;
   logic             new_wr;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;
   io_status_t       status;

   assign region = decode(addr, IO_BASE);
   assign ram_we = mem_ctrl_wr && (region == REG_RAM);
   // A held strobe at the same address is a repeat, not a new MMIO access.
   assign new_wr = mem_ctrl_wr && (!prev_wr || (addr != prev_addr));
   assign push   = new_wr && (region == REG_CONSOLE);
   assign pop    = out_valid && out_ready;

   always_comb begin
      status          = '0;
      status.count    = 4'(fifo_count);
      status.overflow = overflow;
      status.empty    = fifo_empty;
      status.full     = fifo_full;
   end

   always_comb begin
      rd_byte = '0;
      case (region)
         REG_RAM:     rd_byte = mem[ram_addr];
         REG_CONSOLE: rd_byte = status;
         REG_HALT:    rd_byte = {7'b0, halt};
         default:     rd_byte = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_wr   <= 1'b0;
         prev_addr <= '0;
         halt      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         prev_wr   <= mem_ctrl_wr;
         prev_addr <= addr;
         if (new_wr && (region == REG_HALT) && wdata[0]) halt <= 1'b1;
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   io_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_console_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (wdata),
      .pop       (pop),
      .head      (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;
`else
   logic unused_mmio;

   assign ram_we      = mem_ctrl_wr;
   assign rd_byte     = mem[ram_addr];
   assign out_valid   = 1'b0;
   assign out_data    = '0;
   assign halt        = 1'b0;
   assign unused_mmio = &{1'b0, out_ready, addr[31:ADDR_WIDTH]};
`endif

   // RAM array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               rdata <= '0;
      else if (!mem_ctrl_wr) rdata <= rd_byte;
   end

endmodule

// File: tb/tb_ram_responder.sv
// Testbench for ram_responder: directed scenarios plus random traffic against a queue-based model.
// Exercises the MMIO window when RAM_RESPONDER_MMIO_EN is defined, the pure-RAM map otherwise.
module tb_ram_responder;

   localparam int unsigned AW     = 17;
   localparam int unsigned DEPTH  = 8;
   localparam logic [31:0] IO_B   = 32'h0003_0000;
   localparam logic [31:0] CONS   = IO_B;
   localparam logic [31:0] HALT_A = IO_B + 32'd4;
   localparam logic [31:0] MASK   = 32'h0001_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b0;
   logic        halt;

   always #5 clk = ~clk;

   ram_responder #(
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (DEPTH),
      .IO_BASE    (IO_B)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_ctrl_wr (wr),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .halt        (halt)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0]  ref_mem [int];
   logic [7:0]  fifo_q [$];
   bit          ovf_m;
   bit          halt_m;
   bit          prev_wr_m;
   logic [31:0] prev_addr_m;
   logic [7:0]  rdata_m;
   bit          rdata_known;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      fifo_q.delete();
      ovf_m       = 1'b0;
      halt_m      = 1'b0;
      prev_wr_m   = 1'b0;
      prev_addr_m = '0;
      rdata_m     = '0;
      rdata_known = 1'b1;
   endtask

   function automatic logic [7:0] status_m();
      int n = fifo_q.size();
      return {4'(n), 1'b0, ovf_m, (n == 0), (n == int'(DEPTH))};
   endfunction

   // Apply the effect of one clock edge with the given inputs.
   task automatic model_edge(input bit w, input logic [31:0] a, input logic [7:0] d, input bit rdy);
      int idx = int'(a & MASK);
`ifdef RAM_RESPONDER_MMIO_EN
      bit is_ram   = (a < IO_B);
      bit fresh    = w && (!prev_wr_m || a != prev_addr_m);
      int pre_size = fifo_q.size();
      bit popped   = (pre_size > 0) && rdy;
      if (!w) begin
         rdata_known = 1'b1;
         if (is_ram) begin
            if (ref_mem.exists(idx)) rdata_m = ref_mem[idx];
            else rdata_known = 1'b0;
         end else if (a == CONS) rdata_m = status_m();
         else if (a == HALT_A)   rdata_m = {7'b0, halt_m};
         else                    rdata_m = 8'h00;
      end
      if (popped) void'(fifo_q.pop_front());
      if (w) begin
         if (is_ram) ref_mem[idx] = d;
         else if (fresh && a == CONS) begin
            if (pre_size < int'(DEPTH) || popped) fifo_q.push_back(d);
            else ovf_m = 1'b1;
         end else if (fresh && a == HALT_A && d[0]) halt_m = 1'b1;
      end
      prev_wr_m   = w;
      prev_addr_m = a;
`else
      if (w) ref_mem[idx] = d;
      else if (ref_mem.exists(idx)) begin
         rdata_m     = ref_mem[idx];
         rdata_known = 1'b1;
      end else rdata_known = 1'b0;
      if (rdy) rdata_known = rdata_known;
`endif
   endtask

   task automatic compare_all();
      if (rdata_known) check("rdata", rdata, rdata_m);
      check("out_valid", out_valid, fifo_q.size() != 0);
      if (fifo_q.size() != 0) check("out_data", out_data, fifo_q[0]);
`ifndef RAM_RESPONDER_MMIO_EN
      check("out_data_off", out_data, 8'h00);
`endif
      check("halt", halt, halt_m);
   endtask

   task automatic cycle(input bit w, input logic [31:0] a, input logic [7:0] d, input bit rdy);
      wr        = w;
      addr      = a;
      wdata     = d;
      out_ready = rdy;
      model_edge(w, a, d, rdy);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
   task automatic reset_pulse();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_rdata", rdata, 8'h00);
      check("rst_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_halt", halt, 1'b0);
      #1 rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_0010;
         1:       return 32'h0000_0011;
         2:       return 32'h0001_FFFF;
         3:       return 32'h0002_0010;
         4, 5:    return CONS;
         6:       return HALT_A;
         7:       return IO_B + 32'd1;
         8:       return IO_B + 32'd8;
         default: return 32'hFFFF_FFF0;
      endcase
   endfunction

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata", rdata, 8'h00);
      check("reset_valid", out_valid, 1'b0);
      check("reset_out_data", out_data, 8'h00);
      check("reset_halt", halt, 1'b0);
      #2 rst = 1'b0;

      // RAM write then read
      cycle(1'b1, 32'h10, 8'hA5, 1'b0);
      cycle(1'b1, 32'h10, 8'hA5, 1'b0);
      cycle(1'b0, 32'h10, 8'h00, 1'b0);
      check("ram_rd", rdata, 8'hA5);

`ifdef RAM_RESPONDER_MMIO_EN
      // Held console write yields one entry
      cycle(1'b1, CONS, 8'h48, 1'b0);
      cycle(1'b1, CONS, 8'h48, 1'b0);
      check("held_valid", out_valid, 1'b1);
      check("held_data", out_data, 8'h48);
      cycle(1'b0, CONS, 8'h00, 1'b0);
      check("held_status", rdata, 8'h10);
      cycle(1'b0, 32'h10, 8'h00, 1'b1);

      // Fill to overflow, then drain
      for (int i = 1; i <= 9; i++) begin
         cycle(1'b1, CONS, 8'(i), 1'b0);
         cycle(1'b0, 32'h10, 8'h00, 1'b0);
      end
      cycle(1'b0, CONS, 8'h00, 1'b0);
      check("ovf_status", rdata, 8'h85);
      for (int i = 1; i <= 8; i++) begin
         check("drain_data", out_data, 8'(i));
         cycle(1'b0, 32'h10, 8'h00, 1'b1);
      end
      check("drain_empty", out_valid, 1'b0);

      // Halt register, then async reset clears halt, FIFO and rdata
      cycle(1'b1, CONS, 8'hEE, 1'b0);
      cycle(1'b1, HALT_A, 8'h00, 1'b0);
      cycle(1'b0, HALT_A, 8'h00, 1'b0);
      check("halt_zero", halt, 1'b0);
      check("halt_rd0", rdata, 8'h00);
      cycle(1'b1, HALT_A, 8'h01, 1'b0);
      check("halt_set", halt, 1'b1);
      cycle(1'b0, HALT_A, 8'h00, 1'b0);
      check("halt_rd1", rdata, 8'h01);
      reset_pulse();

      // Push and pop on the same edge while full
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, CONS, 8'h20 + 8'(i), 1'b0);
         cycle(1'b0, 32'h10, 8'h00, 1'b0);
      end
      cycle(1'b1, CONS, 8'h77, 1'b1);
      cycle(1'b0, CONS, 8'h00, 1'b0);
      check("pp_status", rdata, 8'h81);
      for (int i = 0; i < 8; i++) begin
         check("pp_data", out_data, (i < 7) ? 8'h21 + 8'(i) : 8'h77);
         cycle(1'b0, 32'h10, 8'h00, 1'b1);
      end
      check("pp_empty", out_valid, 1'b0);

      // Write held across reset release counts as new
      cycle(1'b1, CONS, 8'h5A, 1'b0);
      reset_pulse();
      cycle(1'b1, CONS, 8'h5A, 1'b0);
      check("rst_held_new", out_data, 8'h5A);
      cycle(1'b0, 32'h10, 8'h00, 1'b1);
`else
      // MMIO disabled: IO_BASE aliases into RAM
      cycle(1'b1, IO_B, 8'h3C, 1'b1);
      cycle(1'b0, IO_B & MASK, 8'h00, 1'b1);
      check("off_alias", rdata, 8'h3C);
      check("off_valid", out_valid, 1'b0);
`endif

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] a;
         a = rand_addr();
         if ($urandom_range(0, 199) == 0) reset_pulse();
         cycle($urandom_range(0, 1) == 1, a, 8'($urandom), $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
